pea_result_drain: RTL
=====================

// Module: pea_result_drain
// PURPOSE
//  Consumer end of the PEA output path: pops result/status pairs from the PEA
//  output FIFOs in lockstep and presents each pair on a valid/ready port to
//  the host. Detects result/status FIFO desynchronisation and counts pairs
//  carrying nonzero status.
// PARAMETERS
//  buffer_size_out  32  depth of each output FIFO
//  RES_W            32  result word width
//  STAT_W           16  status word width
//  DESYNC_LIM       16  cycles one FIFO may be nonempty while the other is empty
//  PW   log2(buffer_size_out), derived; width of population and counter ports
// PORTS
//  clk           in   1        clock; all state changes on rising edge
//  rst           in   1        asynchronous, active-high reset
//  en            in   1        drain enable; sampled only in IDLE
//  result_pop    in   PW       result FIFO population
//  status_pop    in   PW       status FIFO population
//  result_dout   in   RES_W    result FIFO read data
//  status_dout   in   STAT_W   status FIFO read data
//  rd_en_result  out  1        result FIFO pop strobe
//  rd_en_status  out  1        status FIFO pop strobe
//  out_valid     out  1        pair held on out_result/out_status
//  out_ready     in   1        host accepts pair when out_valid&&out_ready
//  out_result    out  RES_W    captured result
//  out_status    out  STAT_W   captured status
//  desync_err    out  1        sticky desynchronisation flag
//  err_clr       in   1        clears desync_err and returns to IDLE
//  pair_count    out  PW       pairs delivered, wraps modulo 2^PW
//  bad_count     out  PW       delivered pairs with out_status!=0, saturates
// BEHAVIOUR
//  Reset: state=IDLE; every output 0.
//  FIFO read data is valid the cycle after rd_en; pops occur only in READ.
//  States:
//   IDLE:    en && result_pop!=0 && status_pop!=0 -> READ.
//            Exactly one pop nonzero: desync counter increments; at DESYNC_LIM
//            set desync_err -> ERROR. Any other condition clears the counter.
//   READ:    rd_en_result=rd_en_status=1 for exactly this cycle -> LATCH.
//   LATCH:   capture result_dout/status_dout -> PRESENT.
//   PRESENT: out_valid=1; outputs stable while out_ready=0. On
//            out_valid&&out_ready: pair_count+1; bad_count+1 if status!=0
//            (saturate at 2^PW-1); -> IDLE.
//   ERROR:   no pops, out_valid=0; err_clr -> IDLE, desync_err=0.
//  Latency: both FIFOs nonempty in IDLE at cycle N -> rd_en at N+1 ->
//   out_valid at N+3. Max throughput one pair per 4 cycles (ready held high).
//  en is ignored outside IDLE; a pair already popped always completes.
//  err_clr outside ERROR has no effect. Two strobes never differ by a cycle.
//  Reset mid-operation: return to IDLE, popped-but-undelivered pair dropped.
// TESTING
//  1 3 pairs preloaded (res 0x00000005/st 0, 0x00000011/st 0, 0x0000002A/st 1),
//    ready=1 -> 3 pairs in order, pair_count=3, bad_count=1, pops 4 apart.
//  2 1 pair, ready=0 for 10 cycles -> out_valid held, data stable, no extra
//    rd_en; ready=1 -> one transfer, pair_count=1.
//  3 result FIFO 1 entry, status empty 16 cycles -> desync_err=1, no pops;
//    err_clr -> desync_err=0, IDLE; status written -> pair delivered.
//  4 en=0 with both FIFOs nonempty -> no rd_en; en=1 -> rd_en next cycle.
//  5 rst=1 asynchronously during PRESENT -> out_valid=0 and counts 0 at once.
//  6 2^PW+1 pairs delivered, status nonzero -> pair_count=1, bad_count=2^PW-1.

Source files
------------

// File: rtl/pea_result_drain.sv
// rtl/pea_result_drain.sv - lockstep result/status FIFO drain with valid/ready host port
// Pops one result/status pair every visit to READ and flags FIFOs that stay out of step.
module pea_result_drain #(
   parameter int buffer_size_out = 32,
   parameter int RES_W           = 32,
   parameter int STAT_W          = 16,
   parameter int DESYNC_LIM      = 16,
   parameter int PW              = $clog2(buffer_size_out)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [PW-1:0]     result_pop,
   input  logic [PW-1:0]     status_pop,
   input  logic [RES_W-1:0]  result_dout,
   input  logic [STAT_W-1:0] status_dout,
   output logic              rd_en_result,
   output logic              rd_en_status,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [RES_W-1:0]  out_result,
   output logic [STAT_W-1:0] out_status,
   output logic              desync_err,
   input  logic              err_clr,
   output logic [PW-1:0]     pair_count,
   output logic [PW-1:0]     bad_count
);

   localparam int CW = $clog2(DESYNC_LIM + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LATCH,
      S_PRESENT,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     dcnt_q, dcnt_d;
   logic              err_q, err_d;
   logic [RES_W-1:0]  res_q, res_d;
   logic [STAT_W-1:0] stat_q, stat_d;
   logic [PW-1:0]     pair_q, pair_d;
   logic [PW-1:0]     bad_q, bad_d;

   logic res_nz, stat_nz;

   assign res_nz  = (result_pop != '0);
   assign stat_nz = (status_pop != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         dcnt_q  <= '0;
         err_q   <= 1'b0;
         res_q   <= '0;
         stat_q  <= '0;
         pair_q  <= '0;
         bad_q   <= '0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         err_q   <= err_d;
         res_q   <= res_d;
         stat_q  <= stat_d;
         pair_q  <= pair_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      err_d   = err_q;
      res_d   = res_q;
      stat_d  = stat_q;
      pair_d  = pair_q;
      bad_d   = bad_q;
      case (state_q)
         S_IDLE: begin
            // The desync watch runs whether or not the drain is enabled.
            if (res_nz && stat_nz) begin
               dcnt_d = '0;
               if (en) state_d = S_READ;
            end else if (res_nz ^ stat_nz) begin
               dcnt_d = dcnt_q + CW'(1);
               if (dcnt_d == CW'(DESYNC_LIM)) begin
                  err_d   = 1'b1;
                  state_d = S_ERROR;
               end
            end else begin
               dcnt_d = '0;
            end
         end
         S_READ: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            res_d   = result_dout;
            stat_d  = status_dout;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (out_ready) begin
               pair_d = pair_q + PW'(1);
               if ((stat_q != '0) && (bad_q != '1)) bad_d = bad_q + PW'(1);
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            if (err_clr) begin
               err_d   = 1'b0;
               dcnt_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Both strobes decode the same state, so they can never skew.
   assign rd_en_result = (state_q == S_READ);
   assign rd_en_status = (state_q == S_READ);
   assign out_valid    = (state_q == S_PRESENT);
   assign out_result   = res_q;
   assign out_status   = stat_q;
   assign desync_err   = err_q;
   assign pair_count   = pair_q;
   assign bad_count    = bad_q;

endmodule
